banked_bram_router: RTL and testbench

//  CPU-bus to BRAM bridge with parametrised widths, programmable read latency and a bank-select register.

---
 rtl/banked_bram_router.sv | 152 +++++++++++++++
 tb/tb_banked_bram_router.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_bram_router.sv
// CPU-bus to BRAM bridge: bank-select register, banked address window and a
// tristate read path whose bus drive starts a programmable number of clocks after the read.
module banked_bram_router #(
  parameter int          P_DATA_W      = 8,
  parameter logic [15:0] P_OFFSET_MASK = 16'h0FFF,
  parameter int          P_OFFSET_W    = 12,
  parameter int          P_BANK_W      = 3,
  parameter logic [15:0] P_BANK_REG    = 16'hFF70,
  parameter logic [15:0] P_WIN_MASK    = 16'hF000,
  parameter logic [15:0] P_WIN_BASE    = 16'hD000,
  parameter int          P_READ_LAT    = 2,
  parameter bit          P_ZERO_IS_ONE = 1'b1
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic [15:0]                    I_ADDR,
  inout  wire  [P_DATA_W-1:0]            IO_DATA,
  input  logic                           I_WE_L,
  input  logic                           I_RE_L,
  input  logic                           I_CS,
  output logic                           O_BRAM_EN,
  output logic                           O_BRAM_WE,
  output logic [P_OFFSET_W+P_BANK_W-1:0] O_BRAM_ADDR,
  output logic [P_DATA_W-1:0]            O_BRAM_DIN,
  input  logic [P_DATA_W-1:0]            I_BRAM_DOUT,
  output logic [P_BANK_W-1:0]            O_BANK,
  output logic                           O_RD_VALID
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam logic [2:0] LP_LAT = 3'(P_READ_LAT);

  // Gathers the masked address bits into a dense offset, lowest mask bit first.
  function automatic logic [P_OFFSET_W-1:0] f_compact(input logic [15:0] a);
    logic [P_OFFSET_W-1:0] v;
    logic [P_OFFSET_W:0]   t;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      if (P_OFFSET_MASK[i]) begin
        t = {a[i], v};
        v = t[P_OFFSET_W:1];
      end
    end
    return v;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_cnt, w_cnt_nxt;
  logic [15:0]           r_addr, w_addr_nxt;
  logic [P_DATA_W-1:0]   r_data, w_data_nxt;
  logic                  r_prev_re;
  logic [P_BANK_W-1:0]   r_bank;
  logic [P_BANK_W-1:0]   w_bank;
  logic [P_BANK_W-1:0]   w_bank_field;
  logic                  w_bank_sel, w_win, w_hit, w_start, w_drive, w_bank_rd;

  assign w_bank_sel   = (I_ADDR == P_BANK_REG);
  assign w_win        = ((I_ADDR & P_WIN_MASK) == P_WIN_BASE);
  assign w_bank       = (P_ZERO_IS_ONE && (r_bank == '0)) ? P_BANK_W'(1) : r_bank;
  assign w_bank_field = w_win ? w_bank : '0;
  assign w_hit        = I_CS && !w_bank_sel;
  assign w_bank_rd    = (r_addr == P_BANK_REG);

  // A new read begins on a fresh strobe or whenever the address moves under a held strobe.
  assign w_start = !I_RE_L && I_WE_L && (I_CS || w_bank_sel) &&
                   (r_prev_re || (I_ADDR != r_addr));

  assign O_BANK      = w_bank;
  assign O_BRAM_ADDR = {w_bank_field, f_compact(I_ADDR)};
  assign O_BRAM_WE   = w_hit && !I_WE_L;
  assign O_BRAM_EN   = w_hit && (!I_WE_L || !I_RE_L);
  assign O_BRAM_DIN  = IO_DATA;

  assign w_drive    = (r_state == S_DRIVE) && !I_RE_L && I_WE_L;
  assign O_RD_VALID = w_drive;
  assign IO_DATA    = w_drive ? r_data : {P_DATA_W{1'bz}};

  // Bank-select register, written regardless of the router select.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_bank <= '0;
    end else if (!I_WE_L && w_bank_sel) begin
      r_bank <= IO_DATA[P_BANK_W-1:0];
    end else begin
      r_bank <= r_bank;
    end
  end

  // Read pipeline state register.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_addr    <= 16'h0000;
      r_data    <= '0;
      r_prev_re <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_prev_re <= I_RE_L;
    end
  end

  // Read next-state: a write always wins, then restart, then latency count and drive.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    if (!I_WE_L) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_WAIT;
      w_cnt_nxt   = 3'd1;
      w_addr_nxt  = I_ADDR;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_WAIT: begin
          if (I_RE_L) begin
            w_state_nxt = S_IDLE;
          end else if (r_cnt == LP_LAT) begin
            w_state_nxt = S_DRIVE;
            w_data_nxt  = w_bank_rd ? {{(P_DATA_W-P_BANK_W){1'b1}}, w_bank} : I_BRAM_DOUT;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        S_DRIVE: begin
          if (I_RE_L) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRIVE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_banked_bram_router.sv
// Bench for banked_bram_router: three instances (read latency 2, 1, 4) share one stimulus
// and are checked every cycle against a behavioural model plus directed literal expectations.
module tb_banked_bram_router;

  logic        I_CLK = 1'b0;
  logic        tb_rst;
  logic [15:0] tb_addr;
  logic        tb_we_l, tb_re_l, tb_cs;
  logic [7:0]  tb_drv;
  logic        tb_drv_en;
  logic [7:0]  tb_dout;
  logic        chk_on = 1'b0;

  logic [7:0]  io_o   [3];
  logic        rdv_o  [3];
  logic [2:0]  bank_o [3];
  logic        en_o   [3];
  logic        we_o   [3];
  logic [14:0] addr_o [3];
  logic [7:0]  din_o  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 I_CLK = ~I_CLK;

  // BRAM contents stand-in: data is a fixed scramble of the low address byte.
  assign tb_dout = tb_addr[7:0] ^ 8'hA4;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic logic [2:0] eff_bank(input logic [2:0] b);
    return (b == 3'd0) ? 3'd1 : b;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    wire [7:0] io;
    pullup (io);
    assign io = tb_drv_en ? tb_drv : 8'hzz;
    assign io_o[g] = io;
    banked_bram_router #(.P_READ_LAT(LAT)) u_dut (
      .I_CLK       (I_CLK),
      .I_RESET     (tb_rst),
      .I_ADDR      (tb_addr),
      .IO_DATA     (io),
      .I_WE_L      (tb_we_l),
      .I_RE_L      (tb_re_l),
      .I_CS        (tb_cs),
      .O_BRAM_EN   (en_o[g]),
      .O_BRAM_WE   (we_o[g]),
      .O_BRAM_ADDR (addr_o[g]),
      .O_BRAM_DIN  (din_o[g]),
      .I_BRAM_DOUT (tb_dout),
      .O_BANK      (bank_o[g]),
      .O_RD_VALID  (rdv_o[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bank value, time since the latest read start, and captured data.
  logic [2:0]  m_bank;
  logic        m_prev_re;
  logic [15:0] m_saddr;
  logic        m_act  [3];
  logic        m_drv  [3];
  int          m_age  [3];
  logic [7:0]  m_data [3];

  wire m_bank_hit = (tb_addr == 16'hFF70);
  wire m_start    = !tb_re_l && tb_we_l && (tb_cs || m_bank_hit) &&
                    (m_prev_re || (tb_addr != m_saddr));
  wire [7:0] m_io_bus = tb_drv_en ? tb_drv : 8'hFF;

  always @(posedge I_CLK or posedge tb_rst) begin
    if (tb_rst) begin
      m_bank    <= 3'd0;
      m_prev_re <= 1'b1;
      m_saddr   <= 16'h0000;
      for (int k = 0; k < 3; k++) begin
        m_act[k]  <= 1'b0;
        m_drv[k]  <= 1'b0;
        m_age[k]  <= 0;
        m_data[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!tb_we_l || tb_re_l) begin
          m_act[k] <= 1'b0;
          m_drv[k] <= 1'b0;
        end else if (m_start) begin
          m_act[k] <= 1'b1;
          m_drv[k] <= 1'b0;
          m_age[k] <= 0;
        end else if (m_act[k] && !m_drv[k]) begin
          m_age[k] <= m_age[k] + 1;
          if (m_age[k] + 1 == lat_of(k)) begin
            m_drv[k]  <= 1'b1;
            m_data[k] <= m_bank_hit ? {5'b11111, eff_bank(m_bank)} : tb_dout;
          end
        end
      end
      if (m_start) m_saddr <= tb_addr;
      if (!tb_we_l && m_bank_hit) m_bank <= m_io_bus[2:0];
      m_prev_re <= tb_re_l;
    end
  end

  // Every-cycle comparison of all instances against the model, mid-cycle.
  always @(negedge I_CLK) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        logic       drives, hit;
        logic [7:0] exp_io;
        logic [2:0] eb;
        eb     = tb_rst ? 3'd1 : eff_bank(m_bank);
        drives = !tb_rst && m_drv[k] && !tb_re_l && tb_we_l;
        exp_io = drives ? m_data[k] : m_io_bus;
        hit    = tb_cs && !m_bank_hit;
        chk($sformatf("m_io%0d", k),   io_o[k],   exp_io);
        chk($sformatf("m_din%0d", k),  din_o[k],  exp_io);
        chk($sformatf("m_rdv%0d", k),  rdv_o[k],  drives);
        chk($sformatf("m_bank%0d", k), bank_o[k], eb);
        chk($sformatf("m_en%0d", k),   en_o[k],   hit && (!tb_we_l || !tb_re_l));
        chk($sformatf("m_we%0d", k),   we_o[k],   hit && !tb_we_l);
        chk($sformatf("m_addr%0d", k), addr_o[k],
            {((tb_addr[15:12] == 4'hD) ? eb : 3'd0), tb_addr[11:0]});
      end
    end
  end

  task automatic step(input logic [15:0] a, input logic we, input logic re, input logic cs);
    @(posedge I_CLK);
    #2;
    tb_addr = a;
    tb_we_l = we;
    tb_re_l = re;
    tb_cs   = cs;
    @(negedge I_CLK);
  endtask

  task automatic wr_bank(input logic [7:0] v);
    tb_drv    = v;
    tb_drv_en = 1'b1;
    step(16'hFF70, 1'b0, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b1, 1'b0);
    tb_drv_en = 1'b0;
  endtask

  initial begin
    tb_rst = 1'b1; tb_addr = 16'h0000; tb_we_l = 1'b1; tb_re_l = 1'b1; tb_cs = 1'b0;
    tb_drv = 8'h00; tb_drv_en = 1'b0;
    @(posedge I_CLK);
    chk_on = 1'b1;
    @(posedge I_CLK);
    #2 tb_rst = 1'b0;
    @(negedge I_CLK);
    chk("rst_bank", bank_o[0], 3'd1);
    chk("rst_rdv",  rdv_o[0],  1'b0);
    chk("rst_io_z", io_o[0],   8'hFF);
    chk("rst_en",   en_o[0],   1'b0);

    // Bank select and address map.
    wr_bank(8'h05);
    chk("bank5", bank_o[0], 3'd5);
    step(16'hD123, 1'b1, 1'b0, 1'b1);
    chk("addr_d123", addr_o[0], 15'h5123);
    chk("en_d123",   en_o[0],   1'b1);
    step(16'hC123, 1'b1, 1'b0, 1'b1);
    chk("addr_c123", addr_o[0], 15'h0123);
    step(16'h0000, 1'b1, 1'b1, 1'b0);
    wr_bank(8'h00);
    chk("bank0_is_1", bank_o[0], 3'd1);

    // Read latency: start edge is the first edge sampling I_RE_L low.
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("lat_pre_io0", io_o[0], 8'hFF);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("lat_e0_io0", io_o[0], 8'hFF);
    chk("lat_e0_io1", io_o[1], 8'hFF);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("lat_e1_io0", io_o[0], 8'hFF);
    chk("lat_e1_io1", io_o[1], 8'hA5);
    chk("lat_e1_rdv1", rdv_o[1], 1'b1);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("lat_e2_io0", io_o[0], 8'hA5);
    chk("lat_e2_rdv0", rdv_o[0], 1'b1);
    chk("lat_e2_io2", io_o[2], 8'hFF);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("lat_e3_io2", io_o[2], 8'hFF);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("lat_e4_io2", io_o[2], 8'hA5);
    step(16'hD001, 1'b1, 1'b1, 1'b1);
    chk("rise_io0", io_o[0], 8'hFF);
    chk("rise_io1", io_o[1], 8'hFF);
    chk("rise_io2", io_o[2], 8'hFF);
    step(16'h0000, 1'b1, 1'b1, 1'b0);
    chk("idle_rdv0", rdv_o[0], 1'b0);

    // Bank-register read.
    wr_bank(8'h05);
    for (int i = 0; i < 4; i++) begin
      step(16'hFF70, 1'b1, 1'b0, 1'b0);
      chk("bankrd_en", en_o[0], 1'b0);
      if (i == 3) chk("bankrd_io0", io_o[0], 8'hFD);
    end
    step(16'h0000, 1'b1, 1'b1, 1'b0);

    // Address change during WAIT restarts the read.
    step(16'hD000, 1'b1, 1'b0, 1'b1);
    step(16'hD000, 1'b1, 1'b0, 1'b1);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("restart_e2_io0", io_o[0], 8'hFF);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("restart_e3_io0", io_o[0], 8'hFF);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("restart_e4_io0", io_o[0], 8'hA5);
    step(16'hD001, 1'b0, 1'b0, 1'b1);
    chk("wr_rd_we",  we_o[0], 1'b1);
    chk("wr_rd_io0", io_o[0], 8'hFF);
    step(16'h0000, 1'b1, 1'b1, 1'b0);

    // Reset while driving.
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    step(16'hD001, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_io0", io_o[0], 8'hA5);
    @(posedge I_CLK);
    #2 tb_rst = 1'b1;
    @(negedge I_CLK);
    chk("mid_rst_io0",   io_o[0],   8'hFF);
    chk("mid_rst_bank0", bank_o[0], 3'd1);
    chk("mid_rst_rdv0",  rdv_o[0],  1'b0);
    @(posedge I_CLK);
    #2;
    tb_rst = 1'b0; tb_re_l = 1'b1; tb_cs = 1'b0; tb_addr = 16'h0000;
    step(16'h0000, 1'b1, 1'b1, 1'b0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
